// File: rtl/aes_block_tx_sequencer_pkg.sv
// Shared constants for the AES block transmit path: FSM encodings and block defaults.
package aes_block_tx_sequencer_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam int         AES_BLOCK_BYTES = 16;
  localparam logic [7:0] DEF_SYNC_BYTE   = 8'hA5;

endpackage

// File: rtl/aes_block_tx_sequencer_byte_watchdog.sv
// Per-byte watchdog: counts cycles while enabled, flags when TIMEOUT_CYCLES-1 is reached.
module byte_watchdog #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_W           = 18
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  assign expired = (cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Saturate at the expiry value so a stalled FSM never wraps the counter.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                      cnt <= '0;
    else if (clear)               cnt <= '0;
    else if (enable && !expired)  cnt <= cnt + TO_W'(1);
  end

endmodule

// File: rtl/aes_block_tx_sequencer.sv
// Streams a latched 128-bit AES block to the UART byte writer, one byte per WriteByteReady.
module aes_block_tx_sequencer
  import aes_block_tx_sequencer_pkg::*;
#(
  parameter int         NBYTES         = AES_BLOCK_BYTES,
  parameter int         MSB_FIRST      = 1,
  parameter int         SYNC_EN        = 0,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter int         TO_W           = 18
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   block_in,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [4:0]            bytes_sent,
  output logic                  WriteEn,
  output logic                  loadNewByte,
  output logic [7:0]            writeByte,
  input  logic                  WriteByteReady
);

  localparam int BW    = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0] TOTAL = IDX_W'(NBYTES + ((SYNC_EN != 0) ? 1 : 0));

  logic [2:0]       state;
  logic [BW-1:0]    shReg, src, srcShift;
  logic [IDX_W-1:0] idx;
  logic [7:0]       curByte;
  logic             isSync, wdExp;

  // idx counts bytes already handed to the writer, so the byte chosen at start
  // comes straight from block_in and later bytes from the shift register.
  always_comb begin
    src      = (state == S_IDLE) ? block_in : shReg;
    isSync   = (SYNC_EN != 0) && (state == S_IDLE);
    srcShift = (MSB_FIRST != 0) ? {src[BW-9:0], 8'h00} : {8'h00, src[BW-1:8]};
    if (isSync)              curByte = SYNC_BYTE;
    else if (MSB_FIRST != 0) curByte = src[BW-1 -: 8];
    else                     curByte = src[7:0];
  end

  byte_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) uWdog (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   (state == S_LOAD),
    .enable  (state == S_WAIT),
    .expired (wdExp)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= S_IDLE;
      shReg       <= '0;
      idx         <= '0;
      bytes_sent  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      WriteEn     <= 1'b0;
      loadNewByte <= 1'b0;
      writeByte   <= 8'h00;
    end else begin
      done        <= 1'b0;
      loadNewByte <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state       <= S_LOAD;
          shReg       <= isSync ? block_in : srcShift;
          idx         <= IDX_W'(1);
          bytes_sent  <= '0;
          timeout_err <= 1'b0;
          busy        <= 1'b1;
          WriteEn     <= 1'b1;
          loadNewByte <= 1'b1;
          writeByte   <= curByte;
        end
        S_LOAD: state <= S_WAIT;
        S_WAIT: begin
          if (WriteByteReady) begin
            if (!((SYNC_EN != 0) && (idx == IDX_W'(1))))
              bytes_sent <= bytes_sent + 5'd1;
            if (idx < TOTAL) begin
              state       <= S_LOAD;
              shReg       <= srcShift;
              idx         <= idx + IDX_W'(1);
              loadNewByte <= 1'b1;
              writeByte   <= curByte;
            end else begin
              state   <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              WriteEn <= 1'b0;
            end
          end else if (wdExp) begin
            state       <= S_ERR;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            WriteEn     <= 1'b0;
          end
        end
        S_DONE, S_ERR: state <= S_IDLE;
        default:       state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_tx_sequencer.sv
// Directed bench: two sequencer configurations, each driving a behavioural byte-writer model.
module tb_aes_block_tx_sequencer;

  localparam logic [127:0] BLK  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK2 = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;

  logic         clk = 1'b0;
  logic         rst;
  logic         startS [2];
  logic [127:0] blkS   [2];
  logic         busyS  [2];
  logic         doneS  [2];
  logic         errS   [2];
  logic [4:0]   bsS    [2];
  logic         weS    [2];
  logic         ldS    [2];
  logic [7:0]   wbS    [2];
  logic         rdyS   [2];

  // writer model controls
  logic mute     [2];
  logic forceRdy [2];
  int   dly      [2];

  int nChk  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  // dut0: MSB first, no sync.  dut1: LSB first with sync lead-in.
  aes_block_tx_sequencer #(.MSB_FIRST(1), .SYNC_EN(0), .TIMEOUT_CYCLES(50), .TO_W(6)) dut0 (
    .Clk(clk), .Rst(rst), .start(startS[0]), .block_in(blkS[0]), .busy(busyS[0]),
    .done(doneS[0]), .timeout_err(errS[0]), .bytes_sent(bsS[0]), .WriteEn(weS[0]),
    .loadNewByte(ldS[0]), .writeByte(wbS[0]), .WriteByteReady(rdyS[0]));

  aes_block_tx_sequencer #(.MSB_FIRST(0), .SYNC_EN(1), .TIMEOUT_CYCLES(50), .TO_W(6)) dut1 (
    .Clk(clk), .Rst(rst), .start(startS[1]), .block_in(blkS[1]), .busy(busyS[1]),
    .done(doneS[1]), .timeout_err(errS[1]), .bytes_sent(bsS[1]), .WriteEn(weS[1]),
    .loadNewByte(ldS[1]), .writeByte(wbS[1]), .WriteByteReady(rdyS[1]));

  // Writer model: captures each loaded byte, pulses ready dly cycles into WAIT.
  for (genvar g = 0; g < 2; g++) begin : wr
    int         ncap    = 0;
    int         doneCnt = 0;
    int         cnt     = 0;
    logic       fire    = 1'b0;
    logic [7:0] cap [256];
    assign rdyS[g] = forceRdy[g] || (fire && !mute[g]);
    always @(negedge clk) begin
      if (doneS[g]) doneCnt++;
      if (ldS[g]) begin
        cap[ncap % 256] = wbS[g];
        ncap++;
        cnt  = dly[g];
        fire = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        fire = (cnt == 0);
      end else begin
        fire = 1'b0;
      end
    end
  end

  function automatic int nFrames(input int g);
    return (g == 0) ? wr[0].ncap : wr[1].ncap;
  endfunction

  function automatic int nDone(input int g);
    return (g == 0) ? wr[0].doneCnt : wr[1].doneCnt;
  endfunction

  function automatic logic [7:0] capAt(input int g, input int i);
    return (g == 0) ? wr[0].cap[i % 256] : wr[1].cap[i % 256];
  endfunction

  // mode 0: BLK msb-first, 1: BLK lsb-first with A5 lead-in, 2: BLK2 msb-first
  function automatic logic [7:0] expByte(input int mode, input int i);
    case (mode)
      0:       return 8'(i * 17);
      1:       return (i == 0) ? 8'hA5 : 8'((16 - i) * 17);
      default: return 8'(240 - 15 * i);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulseStart(input int g, input logic [127:0] blk);
    blkS[g]   = blk;
    startS[g] = 1'b1;
    tick();
    startS[g] = 1'b0;
  endtask

  task automatic waitIdle(input int g, input int budget);
    int n = 0;
    while (busyS[g] && n < budget) begin
      tick();
      n++;
    end
    if (busyS[g]) chk("idle_wait", 32'(busyS[g]), 32'd0);
  endtask

  task automatic chkBlock(input int g, input int base, input int n, input int mode, input string tag);
    chk({tag, "_frames"}, 32'(nFrames(g) - base), 32'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(capAt(g, base + i)), 32'(expByte(mode, i)));
  endtask

  initial begin
    int base, d0, waits, n;
    logic p3, p10;
    for (int g = 0; g < 2; g++) begin
      startS[g] = 1'b0; blkS[g] = '0; mute[g] = 1'b0; forceRdy[g] = 1'b0; dly[g] = 3;
    end
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(busyS[0]), 32'd0);
    chk("rst_done", 32'(doneS[0]), 32'd0);
    chk("rst_err",  32'(errS[0]),  32'd0);
    chk("rst_bs",   32'(bsS[0]),   32'd0);
    chk("rst_we",   32'(weS[0]),   32'd0);
    chk("rst_ld",   32'(ldS[0]),   32'd0);
    chk("rst_wb",   32'(wbS[0]),   32'd0);
    rst = 1'b0;
    tick();

    // 1: basic MSB-first block, start -> first load in one cycle
    base = nFrames(0); d0 = nDone(0);
    pulseStart(0, BLK);
    chk("t1_busy", 32'(busyS[0]), 32'd1);
    chk("t1_ld",   32'(ldS[0]),   32'd1);
    chk("t1_we",   32'(weS[0]),   32'd1);
    chk("t1_wb0",  32'(wbS[0]),   32'h00);
    waitIdle(0, 500);
    chk("t1_done_busy", 32'(doneS[0]), 32'd1);
    tick();
    chkBlock(0, base, 16, 0, "t1");
    chk("t1_bs",    32'(bsS[0]), 32'd16);
    chk("t1_ndone", 32'(nDone(0) - d0), 32'd1);
    chk("t1_err",   32'(errS[0]), 32'd0);
    chk("t1_we_idle", 32'(weS[0]), 32'd0);

    // 2: LSB-first with sync lead-in
    base = nFrames(1);
    pulseStart(1, BLK);
    chk("t2_wb0", 32'(wbS[1]), 32'hA5);
    waitIdle(1, 500);
    tick();
    chkBlock(1, base, 17, 1, "t2");
    chk("t2_bs", 32'(bsS[1]), 32'd16);

    // 3: starts while busy are ignored, then a start right after done is taken
    base = nFrames(0); d0 = nDone(0);
    pulseStart(0, BLK);
    p3 = 1'b0; p10 = 1'b0; n = 0;
    while (busyS[0] && n < 500) begin
      if (!p3 && nFrames(0) - base == 3)        begin p3 = 1'b1;  blkS[0] = BLK2; startS[0] = 1'b1; end
      else if (!p10 && nFrames(0) - base == 10) begin p10 = 1'b1; blkS[0] = BLK2; startS[0] = 1'b1; end
      tick();
      startS[0] = 1'b0;
      n++;
    end
    chk("t3_idle", 32'(busyS[0]), 32'd0);
    tick();
    chkBlock(0, base, 16, 0, "t3a");
    chk("t3_ndone", 32'(nDone(0) - d0), 32'd1);
    base = nFrames(0);
    pulseStart(0, BLK2);
    chk("t3_busy2", 32'(busyS[0]), 32'd1);
    waitIdle(0, 500);
    tick();
    chkBlock(0, base, 16, 2, "t3b");

    // 4: writer never ready -> ERR after 50 WAIT cycles; next start clears it
    mute[0] = 1'b1; d0 = nDone(0); waits = 0; n = 0;
    pulseStart(0, BLK);
    while (busyS[0] && n < 200) begin
      if (weS[0] && !ldS[0]) waits++;
      tick();
      n++;
    end
    chk("t4_waits", 32'(waits),   32'd50);
    chk("t4_err",   32'(errS[0]), 32'd1);
    chk("t4_we",    32'(weS[0]),  32'd0);
    chk("t4_done",  32'(doneS[0]), 32'd0);
    tick();
    chk("t4_ndone", 32'(nDone(0) - d0), 32'd0);
    chk("t4_err_sticky", 32'(errS[0]), 32'd1);
    chk("t4_bs", 32'(bsS[0]), 32'd0);
    mute[0] = 1'b0;
    pulseStart(0, BLK);
    chk("t4_err_clr", 32'(errS[0]), 32'd0);
    waitIdle(0, 500);
    tick();
    chk("t4_bs2", 32'(bsS[0]), 32'd16);

    // 5: reset mid-byte 7, then a full block from byte 0
    pulseStart(0, BLK);
    n = 0;
    while (bsS[0] != 5'd6 && n < 500) begin tick(); n++; end
    chk("t5_reach", 32'(bsS[0]), 32'd6);
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busyS[0]), 32'd0);
    chk("t5_we",   32'(weS[0]),   32'd0);
    chk("t5_ld",   32'(ldS[0]),   32'd0);
    chk("t5_wb",   32'(wbS[0]),   32'd0);
    chk("t5_bs",   32'(bsS[0]),   32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    base = nFrames(0);
    pulseStart(0, BLK);
    waitIdle(0, 500);
    tick();
    chkBlock(0, base, 16, 0, "t5");

    // 6a: ready held high through LOAD -> every byte still sent once
    forceRdy[0] = 1'b1;
    base = nFrames(0);
    pulseStart(0, BLK);
    waitIdle(0, 200);
    tick();
    forceRdy[0] = 1'b0;
    chkBlock(0, base, 16, 0, "t6a");
    chk("t6a_bs", 32'(bsS[0]), 32'd16);

    // 6b: ready lands on the watchdog's final cycle -> counted, no ERR
    dly[0] = 50;
    base = nFrames(0);
    pulseStart(0, BLK);
    waitIdle(0, 2000);
    tick();
    chk("t6b_err",    32'(errS[0]), 32'd0);
    chk("t6b_bs",     32'(bsS[0]),  32'd16);
    chk("t6b_frames", 32'(nFrames(0) - base), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
